// File: rtl/lab_pkg.sv
// rtl/lab_pkg.sv - shared types and constants for the LED lab blocks
package lab_pkg;

  typedef enum logic [1:0] {
    S_WALK_IDLE,
    S_WALK_MOVE,
    S_WALK_SETTLED
  } walker_state_t;

  localparam logic [3:0] BLANK_INDEX          = 4'hF;
  localparam int         DEFAULT_TICK_DIVISOR = 25_000_000;

endpackage

// File: rtl/index_to_one_hot.sv
// rtl/index_to_one_hot.sv - 4-bit index to NUM_POS-bit one-hot decode, zero when out of range
module index_to_one_hot #(
  parameter int NUM_POS = 10
) (
  input  logic [3:0]         index_i,
  output logic [NUM_POS-1:0] one_hot_o
);

  always_comb begin
    one_hot_o = '0;
    for (int k = 0; k < NUM_POS; k++) begin
      one_hot_o[k] = (index_i == 4'(k));
    end
  end

endmodule

// File: rtl/led_position_walker.sv
// rtl/led_position_walker.sv - one-hot LED bar whose lit position walks one step per tick toward a target
module led_position_walker
  import lab_pkg::*;
#(
  parameter int TICK_DIVISOR = DEFAULT_TICK_DIVISOR,
  parameter int NUM_POS      = 10
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic [3:0]         target_i,
  input  logic               load_i,
  output logic [NUM_POS-1:0] one_hot_o,
  output logic [3:0]         position_o,
  output logic               moving_o,
  output logic               done_o
);

  localparam int CNT_W = (TICK_DIVISOR > 2) ? $clog2(TICK_DIVISOR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIVISOR - 1);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  walker_state_t    r_state, w_state_nxt;
  logic [3:0]       r_position, w_position_nxt;
  logic [3:0]       r_target, w_target_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_done, w_done_nxt;
  logic             w_load_blank, w_load_valid;
  logic [3:0]       w_goal, w_step;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) r_rst_sync <= 2'b00;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_load_blank = load_i && (target_i == BLANK_INDEX);
  assign w_load_valid = load_i && (target_i < 4'(NUM_POS));

  always_comb begin
    w_state_nxt    = r_state;
    w_position_nxt = r_position;
    w_target_nxt   = r_target;
    w_cnt_nxt      = '0;
    w_done_nxt     = 1'b0;
    w_goal         = w_load_valid ? target_i : r_target;
    w_step         = (w_goal > r_position) ? r_position + 4'd1 : r_position - 4'd1;

    if (w_load_blank) begin
      w_state_nxt    = S_WALK_IDLE;
      w_position_nxt = BLANK_INDEX;
      w_target_nxt   = '0;
    end else begin
      case (r_state)
        S_WALK_IDLE: begin
          if (w_load_valid) begin
            w_position_nxt = 4'd0;
            w_target_nxt   = target_i;
            if (target_i == 4'd0) begin
              w_state_nxt = S_WALK_SETTLED;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_WALK_MOVE;
            end
          end
        end
        S_WALK_SETTLED: begin
          if (w_load_valid) begin
            w_target_nxt = target_i;
            if (target_i == r_position) w_done_nxt  = 1'b1;
            else                        w_state_nxt = S_WALK_MOVE;
          end
        end
        S_WALK_MOVE: begin
          // A retarget keeps the running count so the step cadence is unbroken.
          w_target_nxt = w_goal;
          if (w_load_valid && (target_i == r_position)) begin
            w_state_nxt = S_WALK_SETTLED;
            w_done_nxt  = 1'b1;
          end else if (r_cnt == CNT_LAST) begin
            w_position_nxt = w_step;
            if (w_step == w_goal) begin
              w_state_nxt = S_WALK_SETTLED;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt    = S_WALK_IDLE;
          w_position_nxt = BLANK_INDEX;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= S_WALK_IDLE;
      r_position <= BLANK_INDEX;
      r_target   <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_position <= w_position_nxt;
      r_target   <= w_target_nxt;
      r_cnt      <= w_cnt_nxt;
      r_done     <= w_done_nxt;
    end
  end

  index_to_one_hot #(
    .NUM_POS (NUM_POS)
  ) u_decode (
    .index_i   (r_position),
    .one_hot_o (one_hot_o)
  );

  assign position_o = r_position;
  assign moving_o   = (r_state == S_WALK_MOVE);
  assign done_o     = r_done;

endmodule

// File: tb/tb_led_position_walker.sv
// tb/tb_led_position_walker.sv - directed self-checking bench for led_position_walker
module tb_led_position_walker;

  logic       Clock;
  logic       Resetn;
  logic [3:0] target_i;
  logic       load_i;
  logic [9:0] one_hot_o;
  logic [3:0] position_o;
  logic       moving_o;
  logic       done_o;

  int n_cmp;
  int n_err;
  int done_cnt;

  led_position_walker #(
    .TICK_DIVISOR (4),
    .NUM_POS      (10)
  ) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .target_i   (target_i),
    .load_i     (load_i),
    .one_hot_o  (one_hot_o),
    .position_o (position_o),
    .moving_o   (moving_o),
    .done_o     (done_o)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(negedge Clock) if (done_o === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic load(input logic [3:0] t);
    target_i = t;
    load_i   = 1'b1;
    tick(1);
    load_i   = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] pos, input logic mov, input logic dn);
    logic [9:0] oh;
    oh = (pos < 4'd10) ? (10'd1 << pos) : 10'd0;
    chk({tag, ".pos"},  32'(position_o), 32'(pos));
    chk({tag, ".oh"},   32'(one_hot_o),  32'(oh));
    chk({tag, ".mov"},  32'(moving_o),   32'(mov));
    chk({tag, ".done"}, 32'(done_o),     32'(dn));
  endtask

  initial begin
    n_cmp = 0; n_err = 0; done_cnt = 0;
    Resetn = 1'b0; load_i = 1'b0; target_i = 4'd0;
    tick(3);
    chk_all("reset", 4'hF, 1'b0, 1'b0);
    Resetn = 1'b1;
    tick(4);
    chk_all("idle", 4'hF, 1'b0, 1'b0);

    // Load 3 from IDLE: 0 immediately, then a step every 4 cycles.
    load(4'd3);
    chk_all("l3.start", 4'd0, 1'b1, 1'b0);
    tick(3);
    chk_all("l3.hold", 4'd0, 1'b1, 1'b0);
    tick(1);
    chk_all("l3.p1", 4'd1, 1'b1, 1'b0);
    tick(4);
    chk_all("l3.p2", 4'd2, 1'b1, 1'b0);
    tick(4);
    chk_all("l3.p3", 4'd3, 1'b0, 1'b1);
    chk("l3.oh_exact", 32'(one_hot_o), 32'h008);
    tick(1);
    chk_all("l3.settled", 4'd3, 1'b0, 1'b0);
    chk("l3.done_cnt", 32'(done_cnt), 32'd1);

    // Retarget to 1 while walking toward 9, right after the step to 5.
    load(4'd9);
    chk_all("r9.start", 4'd3, 1'b1, 1'b0);
    tick(4);
    chk_all("r9.p4", 4'd4, 1'b1, 1'b0);
    tick(4);
    chk_all("r9.p5", 4'd5, 1'b1, 1'b0);
    load(4'd1);
    chk_all("r1.load", 4'd5, 1'b1, 1'b0);
    tick(2);
    chk_all("r1.hold", 4'd5, 1'b1, 1'b0);
    tick(1);
    chk_all("r1.p4", 4'd4, 1'b1, 1'b0);
    tick(4);
    chk_all("r1.p3", 4'd3, 1'b1, 1'b0);
    tick(4);
    chk_all("r1.p2", 4'd2, 1'b1, 1'b0);
    tick(4);
    chk_all("r1.p1", 4'd1, 1'b0, 1'b1);
    tick(1);
    chk("r1.done_cnt", 32'(done_cnt), 32'd2);

    load(4'hC);
    chk_all("invalid", 4'd1, 1'b0, 1'b0);
    tick(3);
    chk_all("invalid.hold", 4'd1, 1'b0, 1'b0);

    load(4'd1);
    chk_all("same", 4'd1, 1'b0, 1'b1);
    tick(1);
    chk_all("same.after", 4'd1, 1'b0, 1'b0);
    chk("same.done_cnt", 32'(done_cnt), 32'd3);

    load(4'hF);
    chk_all("blank", 4'hF, 1'b0, 1'b0);
    tick(2);
    chk("blank.done_cnt", 32'(done_cnt), 32'd3);

    load(4'd0);
    chk_all("zero", 4'd0, 1'b0, 1'b1);
    load(4'hF);
    chk_all("zero.blank", 4'hF, 1'b0, 1'b0);
    chk("zero.done_cnt", 32'(done_cnt), 32'd4);

    // Asynchronous reset between edges while walking 0 -> 9.
    load(4'd9);
    chk_all("a9.start", 4'd0, 1'b1, 1'b0);
    tick(16);
    chk_all("a9.p4", 4'd4, 1'b1, 1'b0);
    #2;
    Resetn = 1'b0;
    #1;
    chk_all("async", 4'hF, 1'b0, 1'b0);
    tick(2);
    Resetn = 1'b1;
    tick(12);
    chk_all("async.after", 4'hF, 1'b0, 1'b0);
    chk("async.done_cnt", 32'(done_cnt), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
